// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: owns HI/LO and holds busy for a fixed latency.
// Define MDU_MADD_EN to build madd/maddu/msub/msubu (ops 7-10); otherwise they act as reserved.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOP,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        is_mul, is_div, is_sgn, is_mthi, is_mtlo;
  logic [63:0] op_a, op_b, prod, mul_res;
  logic        a_neg, b_neg, div_by_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
`ifdef MDU_MADD_EN
  logic        is_acc, is_sub;
`endif

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_sgn  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
`ifdef MDU_MADD_EN
    is_acc  = 1'b0;
    is_sub  = 1'b0;
`endif
    case (MDUOP)
      OP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
      OP_MTHI:  is_mthi = 1'b1;
      OP_MTLO:  is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; is_sgn = 1'b1; is_acc = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
      OP_MSUB:  begin is_mul = 1'b1; is_sgn = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
      OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Extending both operands to 64 bits lets one unsigned multiplier serve signed and unsigned ops.
  always_comb begin
    op_a = is_sgn ? {{32{A[31]}}, A} : {32'd0, A};
    op_b = is_sgn ? {{32{B[31]}}, B} : {32'd0, B};
    prod = op_a * op_b;
`ifdef MDU_MADD_EN
    if (is_acc)
      mul_res = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
    else
      mul_res = prod;
`else
    mul_res = prod;
`endif
  end

  // Signed divide runs on magnitudes; quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    a_neg       = is_sgn & A[31];
    b_neg       = is_sgn & B[31];
    a_mag       = a_neg ? (32'd0 - A) : A;
    b_mag       = b_neg ? (32'd0 - B) : B;
    div_by_zero = (B == 32'd0);
    b_safe      = div_by_zero ? 32'd1 : b_mag;
    q_mag       = a_mag / b_safe;
    r_mag       = a_mag % b_safe;
    quo         = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem         = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul) begin
            {pend_hi_d, pend_lo_d} = mul_res;
            pend_wr_d = 1'b1;
            cnt_d     = MULT_LAST;
            state_d   = S_BUSY;
          end else if (is_div) begin
            pend_hi_d = rem;
            pend_lo_d = quo;
            pend_wr_d = ~div_by_zero;
            cnt_d     = DIV_LAST;
            state_d   = S_BUSY;
          end else if (is_mthi) begin
            hi_d = A;
          end else if (is_mtlo) begin
            lo_d = A;
          end
        end
      end
      default: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign dbg_state = state_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vector table, multi-cycle corner sequences, and random ops
// checked against an arithmetic reference model of HI/LO and busy latency.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] A, B;
  logic [3:0]  MDUOP;
  logic        busy, dbg_state;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOP(MDUOP), .start(start),
    .busy(busy), .HI(HI), .LO(LO), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  vec_t vtab[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one op, optionally poke a second start at busy cycle inj_at, and count busy cycles.
  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input logic [3:0] inj_op, input logic [31:0] inj_a,
                          output int lat);
    @(negedge clk);
    MDUOP = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOP = 4'd0;
    lat = 0;
    while (busy && lat < 40) begin
      lat++;
      if (lat == inj_at) begin
        start = 1'b1; MDUOP = inj_op; A = inj_a;
      end
      @(negedge clk);
      start = 1'b0; MDUOP = 4'd0;
    end
  endtask

  // Reference: architectural effect of one op on HI/LO and its busy latency.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo, output int lat);
    logic [63:0] r;
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 0;
    case (op)
      4'd1: begin r = sa * sb; {hi, lo} = r; lat = MC; end
      4'd2: begin r = {32'd0, a} * {32'd0, b}; {hi, lo} = r; lat = MC; end
      4'd3: begin
        lat = DC;
        if (b != 0) begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      4'd4: begin
        lat = DC;
        if (b != 0) begin lo = a / b; hi = a % b; end
      end
      4'd5: hi = a;
      4'd6: lo = a;
`ifdef MDU_MADD_EN
      4'd7:  begin r = {hi, lo} + 64'(sa * sb); {hi, lo} = r; lat = MC; end
      4'd8:  begin r = {hi, lo} + {32'd0, a} * {32'd0, b}; {hi, lo} = r; lat = MC; end
      4'd9:  begin r = {hi, lo} - 64'(sa * sb); {hi, lo} = r; lat = MC; end
      4'd10: begin r = {hi, lo} - {32'd0, a} * {32'd0, b}; {hi, lo} = r; lat = MC; end
`endif
      default: ;
    endcase
  endtask

  initial begin
    int lat, lat_e;
    logic [31:0] hi_m, lo_m;
    logic [63:0] e;

    vtab[0]  = '{4'd1,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MC};
    vtab[1]  = '{4'd4,  32'd7,        32'd2,        32'd1,        32'd3,        DC};
    vtab[2]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vtab[3]  = '{4'd5,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFD, 0};
    vtab[4]  = '{4'd6,  32'h1234,     32'd0,        32'd5,        32'h1234,     0};
    vtab[5]  = '{4'd3,  32'd7,        32'd0,        32'd5,        32'h1234,     DC};
    vtab[6]  = '{4'd0,  32'hDEAD,     32'd3,        32'd5,        32'h1234,     0};
    vtab[7]  = '{4'd13, 32'hBEEF,     32'd3,        32'd5,        32'h1234,     0};
    vtab[8]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC};
    vtab[9]  = '{4'd3,  32'd5,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFE, DC};
    vtab[10] = '{4'd2,  32'h10000,    32'h10000,    32'd1,        32'd0,        MC};
`ifdef MDU_MADD_EN
    vtab[11] = '{4'd7,  32'd3,        32'd4,        32'd1,        32'd12,       MC};
`else
    vtab[11] = '{4'd7,  32'd3,        32'd4,        32'd1,        32'd0,        0};
`endif

    // Clock/reset
    reset = 1'b1; start = 1'b0; MDUOP = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_state", {31'd0, dbg_state}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive_op(vtab[i].op, vtab[i].a, vtab[i].b, 0, 4'd0, 32'd0, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vtab[i].lat));
      chk($sformatf("vec%0d_hi", i), HI, vtab[i].hi);
      chk($sformatf("vec%0d_lo", i), LO, vtab[i].lo);
    end

    // mthi issued at busy cycle 2 must be dropped
    drive_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 4'd5, 32'd9, lat);
    chk("inj_lat", 32'(lat), 32'(MC));
    chk("inj_hi", HI, 32'hFFFFFFFE);
    chk("inj_lo", LO, 32'd1);

`ifdef MDU_MADD_EN
    drive_op(4'd6, 32'd10, 32'd0, 0, 4'd0, 32'd0, lat);
    drive_op(4'd5, 32'd0, 32'd0, 0, 4'd0, 32'd0, lat);
    drive_op(4'd7, 32'd3, 32'd4, 0, 4'd0, 32'd0, lat);
    chk("madd_lat", 32'(lat), 32'(MC));
    chk("madd_hi", HI, 32'd0);
    chk("madd_lo", LO, 32'd22);
    drive_op(4'd10, 32'd5, 32'd5, 0, 4'd0, 32'd0, lat);
    chk("msubu_hi", HI, 32'hFFFFFFFF);
    chk("msubu_lo", LO, 32'hFFFFFFFD);
`endif

    // Reset in busy cycle 3 of a mult: no late write-back afterwards
    @(negedge clk);
    MDUOP = 4'd1; A = 32'd7; B = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOP = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", HI, 32'd0);
    chk("rst_mid_lo", LO, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rst_after_busy", {31'd0, busy}, 32'd0);
    end
    chk("rst_after_hi", HI, 32'd0);
    chk("rst_after_lo", LO, 32'd0);

    // Random ops against the model, starting from the post-reset HI=LO=0
    hi_m = 32'd0; lo_m = 32'd0;
    for (int i = 0; i < 80; i++) begin
      logic [3:0]  op, iop;
      logic [31:0] a, b, ia;
      int          inj;
      op  = 4'($urandom_range(0, 12));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      inj = $urandom_range(0, 4);
      iop = 4'($urandom_range(1, 10));
      ia  = $urandom;
      model(op, a, b, hi_m, lo_m, lat_e);
      exp_q.push_back({hi_m, lo_m});
      drive_op(op, a, b, inj, iop, ia, lat);
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d_op%0d_lat", i, op), 32'(lat), 32'(lat_e));
      chk($sformatf("rnd%0d_op%0d_hi", i, op), HI, e[63:32]);
      chk($sformatf("rnd%0d_op%0d_lo", i, op), LO, e[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
